// File: rtl/dmem_rmw_port.sv
// Data-memory responder: lane-checked loads and stores against a word-wide SRAM
// without byte enables. Sub-word stores are read-modify-write; loads are sign/zero-extended.
module dmem_rmw_port #(
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [3:0]        req_byte_en,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [3:0]        r_byte_en;
   logic [2:0]        r_funct3;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;
   logic [31:0]       r_mem_wdata;

   logic        w_accept;
   logic        w_be_ok;
   logic [1:0]  w_low_lane;
   logic        w_ld_ok;
   logic        w_noop;
   logic        w_err;
   logic [31:0] w_shifted;
   logic [31:0] w_ld_word;
   logic [31:0] w_ld_data;
   logic [31:0] w_merge;

   assign w_accept  = req_valid & (r_state == S_IDLE);
   assign w_noop    = req_we & (req_byte_en == 4'b0000);
   assign w_shifted = req_wdata << {req_addr[1:0], 3'b000};

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_be_ok    = 1'b0;
      w_low_lane = 2'd0;
      case (req_byte_en)
         4'b0001, 4'b0011, 4'b1111: begin w_be_ok = 1'b1; w_low_lane = 2'd0; end
         4'b0010:                   begin w_be_ok = 1'b1; w_low_lane = 2'd1; end
         4'b0100, 4'b1100:          begin w_be_ok = 1'b1; w_low_lane = 2'd2; end
         4'b1000:                   begin w_be_ok = 1'b1; w_low_lane = 2'd3; end
         default:                   begin w_be_ok = 1'b0; w_low_lane = 2'd0; end
      endcase
      w_ld_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: w_ld_ok = 1'b1;
         3'b001, 3'b101: w_ld_ok = ~req_addr[0];
         3'b010:         w_ld_ok = (req_addr[1:0] == 2'b00);
         default:        w_ld_ok = 1'b0;
      endcase
      // A no-op store is legal and simply completes without touching the SRAM.
      w_err = req_we ? (~w_noop & ~(w_be_ok & (w_low_lane == req_addr[1:0]))) : ~w_ld_ok;
   end

   assign w_ld_word = mem_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_ld_data = w_ld_word;
      case (r_funct3[1:0])
         2'b00:   w_ld_data = {{24{~r_funct3[2] & w_ld_word[7]}},  w_ld_word[7:0]};
         2'b01:   w_ld_data = {{16{~r_funct3[2] & w_ld_word[15]}}, w_ld_word[15:0]};
         default: w_ld_data = w_ld_word;
      endcase
      w_merge = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (r_byte_en[i]) w_merge[8*i +: 8] = r_wdata[8*i +: 8];
      end
   end

   // NOTE: sequential state is assigned only with non-blocking assignments.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_byte_en   <= 4'b0000;
         r_funct3    <= 3'b000;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr    <= req_addr;
                  r_we      <= req_we;
                  r_byte_en <= req_byte_en;
                  r_funct3  <= req_funct3;
                  r_wdata   <= w_shifted;
                  if (w_err | w_noop) begin
                     r_state     <= S_RESP;
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= w_err;
                  end else if (req_we & (req_byte_en == 4'b1111)) begin
                     r_state     <= S_WR;
                     r_mem_wdata <= w_shifted;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_state <= S_WAIT;
               r_cnt   <= CNT_W'(RD_LAT - 1);
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  if (r_we) begin
                     r_state     <= S_WR;
                     r_mem_wdata <= w_merge;
                  end else begin
                     r_state     <= S_RESP;
                     r_rsp_rdata <= w_ld_data;
                     r_rsp_err   <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_WR: begin
               r_state     <= S_RESP;
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset removes them at once.
   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_en    = (r_state == S_RD) | (r_state == S_WR);
   assign mem_we    = (r_state == S_WR);
   assign mem_addr  = r_addr[ADDR_W-1:2];
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Bench for dmem_rmw_port: two instances (read latency 1 and 3) against behavioural
// SRAMs, with expectations from a word-array reference model of the access rules.
module tb_dmem_rmw_port;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid1, valid3;
   logic        req_we;
   logic [3:0]  req_be;
   logic [2:0]  req_f3;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;

   logic        ready1, rv1, err1, en1, we1;
   logic        ready3, rv3, err3, en3, we3;
   logic [31:0] rd1, wd1, mrd1, rd3, wd3, mrd3;
   logic [9:0]  ma1, ma3;

   logic [31:0] sram1 [1024];
   logic [31:0] sram3 [1024];
   logic [31:0] pipe1;
   logic [31:0] p3 [3];
   logic [31:0] refm [2][1024];

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_rd;
   logic [31:0] last_wd;

   always #5 clk = ~clk;

   dmem_rmw_port #(.ADDR_W(12), .RD_LAT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .req_valid(valid1), .req_ready(ready1),
      .req_we(req_we), .req_byte_en(req_be), .req_funct3(req_f3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1),
      .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(mrd1));

   dmem_rmw_port #(.ADDR_W(12), .RD_LAT(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .req_valid(valid3), .req_ready(ready3),
      .req_we(req_we), .req_byte_en(req_be), .req_funct3(req_f3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3),
      .mem_en(en3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(wd3), .mem_rdata(mrd3));

   // Behavioural SRAMs: data appears RD_LAT cycles after the read strobe.
   always @(posedge clk) begin
      if (en1 && we1)  sram1[ma1] <= wd1;
      if (en1 && !we1) pipe1      <= sram1[ma1];
      if (en3 && we3)  sram3[ma3] <= wd3;
      if (en3 && !we3) p3[0]      <= sram3[ma3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mrd1 = pipe1;
   assign mrd3 = p3[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int d, output logic rdy, output logic rv, output logic er,
                         output logic en, output logic we, output logic [31:0] rd,
                         output logic [31:0] wd, output logic [9:0] ad);
      if (d == 0) begin
         rdy = ready1; rv = rv1; er = err1; en = en1; we = we1; rd = rd1; wd = wd1; ad = ma1;
      end else begin
         rdy = ready3; rv = rv3; er = err3; en = en3; we = we3; rd = rd3; wd = wd3; ad = ma3;
      end
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      logic rdy, rv, er, en, we;
      logic [31:0] rd, wd;
      logic [9:0] ad;
      sample(d, rdy, rv, er, en, we, rd, wd, ad);
      check({tag, ".ready"}, 32'(rdy), 32'd1);
      check({tag, ".rsp_valid"}, 32'(rv), 32'd0);
      check({tag, ".rsp_rdata"}, rd, 32'd0);
      check({tag, ".rsp_err"}, 32'(er), 32'd0);
      check({tag, ".mem_en"}, 32'(en), 32'd0);
      check({tag, ".mem_we"}, 32'(we), 32'd0);
      check({tag, ".mem_addr"}, 32'(ad), 32'd0);
      check({tag, ".mem_wdata"}, wd, 32'd0);
   endtask

   // One complete transaction on instance d, checked against the reference model.
   task automatic run(input int d, input logic we, input logic [3:0] be, input logic [2:0] f3,
                      input logic [11:0] addr, input logic [31:0] wdata, input string tag);
      int lat_l, sh, wi, lane, exp_lat, exp_nrd, exp_nwr, exp_wcyc;
      int nrd, nwr, wcyc, rcyc, rsp_k, rdy_hi;
      logic exp_err, noop, full, got;
      logic [31:0] word, shifted, v, exp_rdata, exp_wval, wval, rsp_rd;
      logic [9:0] waddr, raddr;
      logic rdy, rv, er, en, mwe, rsp_er;
      logic [31:0] rd, wd;
      logic [9:0] ad;

      lat_l = (d == 0) ? 1 : 3;
      sh = int'(addr[1:0]);
      wi = int'(addr[11:2]);
      word = refm[d][wi];
      noop = 1'b0; full = 1'b0; exp_rdata = 32'd0; exp_wval = 32'd0;
      if (we) begin
         noop = (be == 4'b0000);
         lane = 0;
         for (int i = 3; i >= 0; i--) if (be[i]) lane = i;
         exp_err = !noop && !((be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0011, 4'b1100, 4'b1111}) && lane == sh);
         full = (be == 4'b1111) && !exp_err;
         shifted = wdata << (8 * sh);
         exp_wval = word;
         for (int i = 0; i < 4; i++) if (be[i]) exp_wval[8*i +: 8] = shifted[8*i +: 8];
      end else begin
         exp_err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                   (f3[1:0] == 2'd1 && addr[0]) || (f3 == 3'd2 && sh != 0);
         v = word >> (8 * sh);
         if (f3[1:0] == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end else if (f3[1:0] == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
         end
         exp_rdata = exp_err ? 32'd0 : v;
      end
      exp_wcyc = 0;
      if (exp_err || noop) begin exp_lat = 1; exp_nrd = 0; exp_nwr = 0; end
      else if (full) begin exp_lat = 2; exp_nrd = 0; exp_nwr = 1; exp_wcyc = 1; end
      else if (we) begin exp_lat = 3 + lat_l; exp_nrd = 1; exp_nwr = 1; exp_wcyc = 2 + lat_l; end
      else begin exp_lat = 2 + lat_l; exp_nrd = 1; exp_nwr = 0; end

      @(negedge clk);
      sample(d, rdy, rv, er, en, mwe, rd, wd, ad);
      check({tag, ".ready_idle"}, 32'(rdy), 32'd1);
      req_we = we; req_be = be; req_f3 = f3; req_addr = addr; req_wdata = wdata;
      if (d == 0) valid1 = 1'b1; else valid3 = 1'b1;
      @(posedge clk);
      #1;
      valid1 = 1'b0; valid3 = 1'b0;
      req_we = 1'($urandom); req_be = 4'($urandom); req_f3 = 3'($urandom);
      req_addr = 12'($urandom); req_wdata = $urandom;

      nrd = 0; nwr = 0; wcyc = 0; rcyc = 0; rsp_k = 0; rdy_hi = 0; got = 1'b0;
      wval = 32'd0; waddr = 10'd0; raddr = 10'd0; rsp_rd = 32'd0; rsp_er = 1'b0;
      for (int k = 1; k <= 30 && !got; k++) begin
         sample(d, rdy, rv, er, en, mwe, rd, wd, ad);
         if (rdy) rdy_hi++;
         if (en && mwe) begin nwr++; wcyc = k; wval = wd; waddr = ad; end
         if (en && !mwe) begin nrd++; rcyc = k; raddr = ad; end
         if (rv) begin got = 1'b1; rsp_k = k; rsp_rd = rd; rsp_er = er; end
         else begin @(posedge clk); #1; end
      end
      check({tag, ".got_rsp"}, 32'(got), 32'd1);
      check({tag, ".latency"}, 32'(rsp_k), 32'(exp_lat));
      check({tag, ".rdata"}, rsp_rd, exp_rdata);
      check({tag, ".err"}, 32'(rsp_er), 32'(exp_err));
      check({tag, ".n_reads"}, 32'(nrd), 32'(exp_nrd));
      check({tag, ".n_writes"}, 32'(nwr), 32'(exp_nwr));
      check({tag, ".ready_busy"}, 32'(rdy_hi), 32'd0);
      if (exp_nrd != 0) begin
         check({tag, ".read_cycle"}, 32'(rcyc), 32'd1);
         check({tag, ".read_addr"}, 32'(raddr), 32'(wi));
      end
      if (exp_nwr != 0) begin
         check({tag, ".write_cycle"}, 32'(wcyc), 32'(exp_wcyc));
         check({tag, ".write_addr"}, 32'(waddr), 32'(wi));
         check({tag, ".write_data"}, wval, exp_wval);
      end
      last_rd = rsp_rd;
      last_wd = wval;

      @(posedge clk);
      #1;
      sample(d, rdy, rv, er, en, mwe, rd, wd, ad);
      check({tag, ".rsp_pulse"}, 32'(rv), 32'd0);
      check({tag, ".ready_after"}, 32'(rdy), 32'd1);
      if (we && !exp_err && !noop) refm[d][wi] = exp_wval;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] be_tab [10];
      logic [2:0] f3_tab [5];
      logic [3:0] be;
      logic [2:0] f3;
      logic [11:0] addr;
      logic we;
      int lo, w, hits;
      be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111,
                 4'b0000, 4'b0110, 4'b1010};
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      reset_n = 1'b0;
      valid1 = 1'b0; valid3 = 1'b0;
      req_we = 1'b0; req_be = 4'b0000; req_f3 = 3'b000; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "reset1");
      check_reset_outputs(1, "reset3");
      reset_n = 1'b1;

      // Establish known contents for word addresses 0..15 in both SRAMs.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) run(d, 1'b1, 4'hF, 3'd0, 12'(i * 4), $urandom, "init");

      run(0, 1'b1, 4'hF, 3'd0, 12'h010, 32'h8899_AABB, "t1_sw");
      run(0, 1'b0, 4'h0, 3'b010, 12'h010, 32'd0, "t1_lw");
      check("t1_lw_const", last_rd, 32'h8899_AABB);
      run(0, 1'b0, 4'h0, 3'b000, 12'h013, 32'd0, "t2_lb");
      check("t2_lb_const", last_rd, 32'hFFFF_FF88);
      run(0, 1'b0, 4'h0, 3'b100, 12'h013, 32'd0, "t2_lbu");
      check("t2_lbu_const", last_rd, 32'h0000_0088);

      run(0, 1'b1, 4'hF, 3'd0, 12'h010, 32'h1122_3344, "t3_pre");
      run(0, 1'b1, 4'b0100, 3'd0, 12'h012, 32'h0000_005A, "t3_sb");
      check("t3_sb_const", last_wd, 32'h115A_3344);

      run(0, 1'b1, 4'hF, 3'd0, 12'h020, 32'hDEAD_BEEF, "t4_sw");
      run(0, 1'b0, 4'h0, 3'b010, 12'h020, 32'd0, "t4_lw");
      check("t4_lw_const", last_rd, 32'hDEAD_BEEF);

      run(0, 1'b0, 4'h0, 3'b001, 12'h011, 32'd0, "t5_lh");
      run(0, 1'b1, 4'b0110, 3'd0, 12'h011, 32'h0000_1234, "t5_sh");
      run(0, 1'b0, 4'h0, 3'b011, 12'h010, 32'd0, "t5_f3");
      run(0, 1'b1, 4'b0000, 3'd0, 12'h014, 32'hFFFF_FFFF, "noop");
      run(1, 1'b1, 4'b1100, 3'd0, 12'h01A, 32'h0000_BEEF, "l3_sh");
      run(1, 1'b0, 4'h0, 3'b001, 12'h01A, 32'd0, "l3_lh");
      check("l3_lh_const", last_rd, 32'hFFFF_BEEF);

      // Reset during the WAIT phase of a partial store on the latency-3 instance.
      @(negedge clk);
      req_we = 1'b1; req_be = 4'b0010; req_f3 = 3'd0; req_addr = 12'h015; req_wdata = 32'h0000_00C3;
      valid3 = 1'b1;
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_outputs(1, "t6_in_reset");
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) reset_n = 1'b1;
         @(negedge clk);
         if ((en3 && we3) || rv3) hits++;
      end
      check("t6_no_write_or_rsp", 32'(hits), 32'd0);
      check("t6_ready", 32'(ready3), 32'd1);
      check("t6_sram_intact", sram3[5], refm[1][5]);
      run(1, 1'b0, 4'h0, 3'b010, 12'h014, 32'd0, "t6_readback");

      // Randomized traffic over the initialized region on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 150; n++) begin
            w = int'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            be = be_tab[$urandom_range(0, 9)];
            f3 = ($urandom_range(0, 3) != 0) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom);
            addr = 12'(w * 4 + int'($urandom_range(0, 3)));
            if (we && $urandom_range(0, 3) != 0) begin
               lo = 0;
               for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
               addr[1:0] = 2'(lo);
            end
            run(d, we, be, f3, addr, $urandom, $sformatf("rnd%0d_%0d", d, n));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
